// File: rtl/trace_pkg.sv
// Shared types for the commit trace buffer: record layout, filter codes,
// capture FSM states and the filter predicate.
package trace_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } trace_state_e;

  localparam logic [1:0] FILT_ALL  = 2'd0;
  localparam logic [1:0] FILT_REG  = 2'd1;
  localparam logic [1:0] FILT_DMEM = 2'd2;
  localparam logic [1:0] FILT_ANY  = 2'd3;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            halt;
    logic            reg_we;
    logic [4:0]      reg_wa;
    logic [XLEN-1:0] reg_wd;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_wa;
    logic [XLEN-1:0] dmem_wd;
  } trace_rec_t;

  localparam int REC_W = $bits(trace_rec_t);

  function automatic logic filter_match(input logic [1:0] f,
                                        input logic reg_we,
                                        input logic dmem_we);
    case (f)
      FILT_REG:  return reg_we;
      FILT_DMEM: return dmem_we;
      FILT_ANY:  return reg_we | dmem_we;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/commit_trace_buf_if.sv
// Commit snoop bus plus host read port of the trace buffer.
// master = core/host side, slave = trace buffer.
interface commit_trace_buf_if #(parameter int XLEN = 32) ();

  logic            commit;
  logic [XLEN-1:0] commit_pc;
  logic [XLEN-1:0] commit_inst;
  logic            commit_halt;
  logic            commit_reg_we;
  logic [4:0]      commit_reg_wa;
  logic [XLEN-1:0] commit_reg_wd;
  logic            commit_dmem_we;
  logic [XLEN-1:0] commit_dmem_wa;
  logic [XLEN-1:0] commit_dmem_wd;

  logic            rd_valid;
  logic            rd_ready;
  logic [XLEN-1:0] rd_pc;
  logic [XLEN-1:0] rd_inst;
  logic            rd_halt;
  logic            rd_reg_we;
  logic [4:0]      rd_reg_wa;
  logic [XLEN-1:0] rd_reg_wd;
  logic            rd_dmem_we;
  logic [XLEN-1:0] rd_dmem_wa;
  logic [XLEN-1:0] rd_dmem_wd;

  modport master (
    output commit, commit_pc, commit_inst, commit_halt,
           commit_reg_we, commit_reg_wa, commit_reg_wd,
           commit_dmem_we, commit_dmem_wa, commit_dmem_wd, rd_ready,
    input  rd_valid, rd_pc, rd_inst, rd_halt, rd_reg_we, rd_reg_wa,
           rd_reg_wd, rd_dmem_we, rd_dmem_wa, rd_dmem_wd
  );

  modport slave (
    input  commit, commit_pc, commit_inst, commit_halt,
           commit_reg_we, commit_reg_wa, commit_reg_wd,
           commit_dmem_we, commit_dmem_wa, commit_dmem_wd, rd_ready,
    output rd_valid, rd_pc, rd_inst, rd_halt, rd_reg_we, rd_reg_wa,
           rd_reg_wd, rd_dmem_we, rd_dmem_wa, rd_dmem_wd
  );

endinterface

// File: rtl/trace_ram.sv
// Record storage: one synchronous write port, one asynchronous read port.
// Contents are never reset; validity is tracked by the controller.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 168
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/commit_trace_buf.sv
// Filtered circular capture of commit records with stop-on-full or overwrite
// modes, halt freeze and a first-word-fall-through host read port.
module commit_trace_buf
  import trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int XLEN   = trace_pkg::XLEN,
  parameter int DROP_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   arm,
  input  logic                   cfg_wrap,
  input  logic [1:0]             cfg_filter,
  commit_trace_buf_if.slave      bus,
  output logic [$clog2(DEPTH):0] count,
  output logic [DROP_W-1:0]      dropped,
  output logic [1:0]             state
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int RAM_W = 5 * XLEN + 8;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  trace_state_e      state_q, state_d;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DROP_W-1:0] dropped_q, dropped_d;
  logic              wrap_q, wrap_d;
  logic [1:0]        filt_q, filt_d;

  logic       full, empty, pop, cap, wr_en, overwrite;
  trace_rec_t wr_rec, rd_rec;
  logic [RAM_W-1:0] ram_rdata;

  assign wr_rec = '{pc:      bus.commit_pc,      inst:    bus.commit_inst,
                    halt:    bus.commit_halt,    reg_we:  bus.commit_reg_we,
                    reg_wa:  bus.commit_reg_wa,  reg_wd:  bus.commit_reg_wd,
                    dmem_we: bus.commit_dmem_we, dmem_wa: bus.commit_dmem_wa,
                    dmem_wd: bus.commit_dmem_wd};

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign pop   = !empty && bus.rd_ready;
  // arm clears the buffer, so a same-cycle commit must not land in it
  assign cap   = (state_q == ST_RUN) && bus.commit && !arm &&
                 (bus.commit_halt ||
                  filter_match(filt_q, bus.commit_reg_we, bus.commit_dmem_we));
  assign wr_en     = cap && (!full || wrap_q);
  assign overwrite = cap && full && wrap_q;

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    dropped_d = dropped_q;
    wrap_d    = wrap_q;
    filt_d    = filt_q;
    if (arm) begin
      state_d   = ST_RUN;
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      dropped_d = '0;
      wrap_d    = cfg_wrap;
      filt_d    = cfg_filter;
    end else begin
      // a rejected halt still freezes capture
      if (cap && bus.commit_halt) state_d = ST_FROZEN;
      if (wr_en) tail_d = tail_q + PW'(1);
      // overwrite and pop both retire the oldest; together they retire it once
      if (pop || overwrite) head_d = head_q + PW'(1);
      if (wr_en && !full && !pop)      count_d = count_q + CW'(1);
      else if (pop && !wr_en)          count_d = count_q - CW'(1);
      if (cap && full && !(wrap_q && pop) && (dropped_q != '1))
        dropped_d = dropped_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      dropped_q <= '0;
      wrap_q    <= 1'b0;
      filt_q    <= FILT_ALL;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      dropped_q <= dropped_d;
      wrap_q    <= wrap_d;
      filt_q    <= filt_d;
    end
  end

  trace_ram #(.DEPTH(DEPTH), .W(RAM_W)) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (tail_q),
    .wdata_i (wr_rec),
    .raddr_i (head_q),
    .rdata_o (ram_rdata)
  );

  assign rd_rec         = trace_rec_t'(ram_rdata);
  assign bus.rd_valid   = !empty;
  assign bus.rd_pc      = rd_rec.pc;
  assign bus.rd_inst    = rd_rec.inst;
  assign bus.rd_halt    = rd_rec.halt;
  assign bus.rd_reg_we  = rd_rec.reg_we;
  assign bus.rd_reg_wa  = rd_rec.reg_wa;
  assign bus.rd_reg_wd  = rd_rec.reg_wd;
  assign bus.rd_dmem_we = rd_rec.dmem_we;
  assign bus.rd_dmem_wa = rd_rec.dmem_wa;
  assign bus.rd_dmem_wd = rd_rec.dmem_wd;

  assign count   = count_q;
  assign dropped = dropped_q;
  assign state   = state_q;

endmodule

// File: tb/tb_commit_trace_buf.sv
// Directed bench for commit_trace_buf (DEPTH=16): capture order, stop and
// wrap modes, filtering, halt freeze, push/pop on full and reset mid-stream.
module tb_commit_trace_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0;
  logic        cfg_wrap = 1'b0;
  logic [1:0]  cfg_filter = 2'd0;
  logic [4:0]  count;
  logic [15:0] dropped;
  logic [1:0]  state;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  commit_trace_buf_if #(.XLEN(32)) bus ();

  commit_trace_buf #(.DEPTH(16), .XLEN(32), .DROP_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .cfg_wrap   (cfg_wrap),
    .cfg_filter (cfg_filter),
    .bus        (bus),
    .count      (count),
    .dropped    (dropped),
    .state      (state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic wrap, input logic [1:0] filt);
    arm = 1'b1; cfg_wrap = wrap; cfg_filter = filt;
    step();
    arm = 1'b0;
  endtask

  task automatic drive_rec(input logic [31:0] pc, input logic rwe,
                           input logic dwe, input logic halt);
    bus.commit         = 1'b1;
    bus.commit_pc      = pc;
    bus.commit_inst    = pc ^ 32'h0000_0013;
    bus.commit_halt    = halt;
    bus.commit_reg_we  = rwe;
    bus.commit_reg_wa  = pc[6:2];
    bus.commit_reg_wd  = ~pc;
    bus.commit_dmem_we = dwe;
    bus.commit_dmem_wa = pc + 32'h1000;
    bus.commit_dmem_wd = pc << 1;
  endtask

  task automatic do_commit(input logic [31:0] pc, input logic rwe,
                           input logic dwe, input logic halt);
    drive_rec(pc, rwe, dwe, halt);
    step();
    bus.commit = 1'b0;
    bus.commit_halt = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    tot_cnt++; if (state !== 2'd0) $display("FAIL reset_state: got %0d exp 0", state); else pass_cnt++;
    tot_cnt++; if (count !== 5'd0) $display("FAIL reset_count: got %0d exp 0", count); else pass_cnt++;
    tot_cnt++; if (dropped !== 16'd0) $display("FAIL reset_dropped: got %0d exp 0", dropped); else pass_cnt++;
    tot_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %0b exp 0", bus.rd_valid); else pass_cnt++;
    // commits in IDLE are ignored
    do_commit(32'hdead_0000, 1'b1, 1'b0, 1'b0);
    tot_cnt++; if (count !== 5'd0) $display("FAIL idle_ignore: got %0d exp 0", count); else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [31:0] exp_pc;
    do_arm(1'b0, 2'd0);
    tot_cnt++; if (state !== 2'd1) $display("FAIL basic_run: got %0d exp 1", state); else pass_cnt++;
    tot_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL basic_empty: got %0b exp 0", bus.rd_valid); else pass_cnt++;
    do_commit(32'h1c00_0000, 1'b1, 1'b0, 1'b0);
    tot_cnt++; if (bus.rd_valid !== 1'b1) $display("FAIL basic_latency: got %0b exp 1", bus.rd_valid); else pass_cnt++;
    tot_cnt++; if (bus.rd_inst !== 32'h1c00_0013) $display("FAIL basic_inst: got %0h exp 1c000013", bus.rd_inst); else pass_cnt++;
    do_commit(32'h1c00_0004, 1'b1, 1'b0, 1'b0);
    do_commit(32'h1c00_0008, 1'b1, 1'b0, 1'b0);
    tot_cnt++; if (count !== 5'd3) $display("FAIL basic_count3: got %0d exp 3", count); else pass_cnt++;
    bus.rd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_pc = 32'h1c00_0000 + 32'(4 * k);
      tot_cnt++; if (bus.rd_pc !== exp_pc) $display("FAIL basic_pop%0d: got %0h exp %0h", k, bus.rd_pc, exp_pc); else pass_cnt++;
      step();
    end
    bus.rd_ready = 1'b0;
    tot_cnt++; if (count !== 5'd0) $display("FAIL basic_count0: got %0d exp 0", count); else pass_cnt++;
    tot_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL basic_drained: got %0b exp 0", bus.rd_valid); else pass_cnt++;
    tot_cnt++; if (dropped !== 16'd0) $display("FAIL basic_dropped: got %0d exp 0", dropped); else pass_cnt++;
  endtask

  task automatic test_stop_full();
    logic [31:0] exp_pc;
    do_arm(1'b0, 2'd0);
    for (int i = 0; i < 20; i++) do_commit(32'h100 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
    tot_cnt++; if (count !== 5'd16) $display("FAIL stop_count: got %0d exp 16", count); else pass_cnt++;
    tot_cnt++; if (dropped !== 16'd4) $display("FAIL stop_dropped: got %0d exp 4", dropped); else pass_cnt++;
    // full, stop mode: pop happens, simultaneous push still rejected
    bus.rd_ready = 1'b1;
    tot_cnt++; if (bus.rd_pc !== 32'h100) $display("FAIL stop_head: got %0h exp 100", bus.rd_pc); else pass_cnt++;
    do_commit(32'h200, 1'b1, 1'b0, 1'b0);
    bus.rd_ready = 1'b0;
    tot_cnt++; if (count !== 5'd15) $display("FAIL stop_pp_count: got %0d exp 15", count); else pass_cnt++;
    tot_cnt++; if (dropped !== 16'd5) $display("FAIL stop_pp_dropped: got %0d exp 5", dropped); else pass_cnt++;
    bus.rd_ready = 1'b1;
    for (int k = 1; k < 16; k++) begin
      exp_pc = 32'h100 + 32'(4 * k);
      tot_cnt++; if (bus.rd_pc !== exp_pc) $display("FAIL stop_drain%0d: got %0h exp %0h", k, bus.rd_pc, exp_pc); else pass_cnt++;
      step();
    end
    bus.rd_ready = 1'b0;
    tot_cnt++; if (count !== 5'd0) $display("FAIL stop_empty: got %0d exp 0", count); else pass_cnt++;
  endtask

  task automatic test_wrap_full();
    logic [31:0] exp_pc;
    do_arm(1'b1, 2'd0);
    for (int i = 0; i < 20; i++) do_commit(32'h100 + 32'(4 * i), 1'b0, 1'b1, 1'b0);
    tot_cnt++; if (count !== 5'd16) $display("FAIL wrap_count: got %0d exp 16", count); else pass_cnt++;
    tot_cnt++; if (dropped !== 16'd4) $display("FAIL wrap_dropped: got %0d exp 4", dropped); else pass_cnt++;
    bus.rd_ready = 1'b1;
    for (int k = 4; k < 20; k++) begin
      exp_pc = 32'h100 + 32'(4 * k);
      tot_cnt++; if (bus.rd_pc !== exp_pc) $display("FAIL wrap_drain%0d: got %0h exp %0h", k, bus.rd_pc, exp_pc); else pass_cnt++;
      step();
    end
    bus.rd_ready = 1'b0;
    tot_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL wrap_empty: got %0b exp 0", bus.rd_valid); else pass_cnt++;
  endtask

  task automatic test_filter();
    logic [31:0] exp_pc;
    do_arm(1'b0, 2'd2);
    for (int i = 0; i < 8; i++)
      do_commit(32'h400 + 32'(4 * i), (i % 2) == 0, (i % 2) == 1, 1'b0);
    tot_cnt++; if (count !== 5'd4) $display("FAIL filt_count: got %0d exp 4", count); else pass_cnt++;
    tot_cnt++; if (dropped !== 16'd0) $display("FAIL filt_dropped: got %0d exp 0", dropped); else pass_cnt++;
    bus.rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_pc = 32'h404 + 32'(8 * k);
      tot_cnt++; if (bus.rd_pc !== exp_pc) $display("FAIL filt_pc%0d: got %0h exp %0h", k, bus.rd_pc, exp_pc); else pass_cnt++;
      tot_cnt++; if (bus.rd_dmem_we !== 1'b1) $display("FAIL filt_dwe%0d: got %0b exp 1", k, bus.rd_dmem_we); else pass_cnt++;
      tot_cnt++; if (bus.rd_dmem_wa !== exp_pc + 32'h1000) $display("FAIL filt_dwa%0d: got %0h exp %0h", k, bus.rd_dmem_wa, exp_pc + 32'h1000); else pass_cnt++;
      step();
    end
    bus.rd_ready = 1'b0;
  endtask

  task automatic test_halt();
    do_arm(1'b0, 2'd1);
    do_commit(32'h600, 1'b1, 1'b0, 1'b0);
    do_commit(32'h604, 1'b1, 1'b0, 1'b0);
    // halt passes even though the filter wants reg_we
    do_commit(32'h608, 1'b0, 1'b0, 1'b1);
    tot_cnt++; if (state !== 2'd2) $display("FAIL halt_frozen: got %0d exp 2", state); else pass_cnt++;
    tot_cnt++; if (count !== 5'd3) $display("FAIL halt_count: got %0d exp 3", count); else pass_cnt++;
    for (int i = 0; i < 5; i++) do_commit(32'h700 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
    tot_cnt++; if (count !== 5'd3) $display("FAIL halt_ignore: got %0d exp 3", count); else pass_cnt++;
    tot_cnt++; if (dropped !== 16'd0) $display("FAIL halt_dropped: got %0d exp 0", dropped); else pass_cnt++;
    // reads still work while frozen
    bus.rd_ready = 1'b1;
    tot_cnt++; if (bus.rd_pc !== 32'h600) $display("FAIL halt_rd: got %0h exp 600", bus.rd_pc); else pass_cnt++;
    step(); step();
    bus.rd_ready = 1'b0;
    tot_cnt++; if (bus.rd_halt !== 1'b1) $display("FAIL halt_rec: got %0b exp 1", bus.rd_halt); else pass_cnt++;
    // arm with a simultaneous commit: clear wins
    drive_rec(32'h800, 1'b1, 1'b0, 1'b0);
    do_arm(1'b0, 2'd0);
    bus.commit = 1'b0;
    tot_cnt++; if (state !== 2'd1) $display("FAIL halt_rearm: got %0d exp 1", state); else pass_cnt++;
    tot_cnt++; if (count !== 5'd0) $display("FAIL halt_clear: got %0d exp 0", count); else pass_cnt++;
  endtask

  task automatic test_full_wrap_pushpop();
    do_arm(1'b1, 2'd0);
    for (int i = 0; i < 16; i++) do_commit(32'h300 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
    tot_cnt++; if (count !== 5'd16) $display("FAIL pp_full: got %0d exp 16", count); else pass_cnt++;
    bus.rd_ready = 1'b1;
    do_commit(32'h400, 1'b1, 1'b0, 1'b0);
    bus.rd_ready = 1'b0;
    tot_cnt++; if (count !== 5'd16) $display("FAIL pp_count: got %0d exp 16", count); else pass_cnt++;
    tot_cnt++; if (dropped !== 16'd0) $display("FAIL pp_dropped: got %0d exp 0", dropped); else pass_cnt++;
    tot_cnt++; if (bus.rd_pc !== 32'h304) $display("FAIL pp_head: got %0h exp 304", bus.rd_pc); else pass_cnt++;
    // reset mid-stream with a commit in flight
    drive_rec(32'h500, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.commit = 1'b0;
    tot_cnt++; if (count !== 5'd0) $display("FAIL rst_count: got %0d exp 0", count); else pass_cnt++;
    tot_cnt++; if (state !== 2'd0) $display("FAIL rst_state: got %0d exp 0", state); else pass_cnt++;
    tot_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL rst_rd_valid: got %0b exp 0", bus.rd_valid); else pass_cnt++;
    step();
    tot_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL rst_rd_valid_next: got %0b exp 0", bus.rd_valid); else pass_cnt++;
  endtask

  initial begin
    bus.commit = 1'b0; bus.commit_pc = '0; bus.commit_inst = '0;
    bus.commit_halt = 1'b0; bus.commit_reg_we = 1'b0; bus.commit_reg_wa = '0;
    bus.commit_reg_wd = '0; bus.commit_dmem_we = 1'b0; bus.commit_dmem_wa = '0;
    bus.commit_dmem_wd = '0; bus.rd_ready = 1'b0;
    test_reset();
    test_basic();
    test_stop_full();
    test_wrap_full();
    test_filter();
    test_halt();
    test_full_wrap_pushpop();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
